// File: rtl/p3_controller.sv
// p3_controller: instruction register, decoder and control FSM driving p3_datapath.
// Latency: MOV imm 3 edges, MOV reg/MVN/CMP 5 edges, ADD/AND 6 edges (s=1 edge to w high).
// Backpressure: load/s are only honoured in WAIT (w=1); they are ignored while busy.
module p3_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [15:0] datapath_in,
  output logic [2:0]  writenum,
  output logic [2:0]  readnum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic        vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop
);

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_ALU       = 3'd5,
    S_WRITE_REG = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_ir;

  // Instruction fields
  logic [2:0] w_opcode;
  logic [1:0] w_op;
  logic [2:0] w_rn;
  logic [2:0] w_rd;
  logic [2:0] w_rm;
  logic [7:0] w_imm8;

  assign w_opcode = r_ir[15:13];
  assign w_op     = r_ir[12:11];
  assign w_rn     = r_ir[10:8];
  assign w_rd     = r_ir[7:5];
  assign w_rm     = r_ir[2:0];
  assign w_imm8   = r_ir[7:0];

  // Instruction classes
  logic w_is_mov_imm;
  logic w_is_mov_reg;
  logic w_is_alu_grp;
  logic w_is_add;
  logic w_is_cmp;
  logic w_is_and;
  logic w_is_mvn;

  assign w_is_mov_imm = (w_opcode == 3'b110) && (w_op == 2'b10);
  assign w_is_mov_reg = (w_opcode == 3'b110) && (w_op == 2'b00);
  assign w_is_alu_grp = (w_opcode == 3'b101);
  assign w_is_add     = w_is_alu_grp && (w_op == 2'b00);
  assign w_is_cmp     = w_is_alu_grp && (w_op == 2'b01);
  assign w_is_and     = w_is_alu_grp && (w_op == 2'b10);
  assign w_is_mvn     = w_is_alu_grp && (w_op == 2'b11);

  // IR-derived outputs are live in every state, independent of the FSM.
  assign datapath_in = {{8{w_imm8[7]}}, w_imm8};
  assign shift       = r_ir[4:3];

  // State register; reset aborts any in-flight instruction immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_WAIT;
    end else begin
      r_state <= w_next;
    end
  end

  // Instruction register: only writable while idle so a busy instruction keeps its fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ir <= 16'h0000;
    end else if (load && (r_state == S_WAIT)) begin
      r_ir <= in;
    end
  end

  // Next-state logic; DECODE sees the IR latched on the same edge that accepted s.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT: begin
        if (s) begin
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_is_mov_imm) begin
          w_next = S_WRITE_IMM;
        end else if (w_is_mov_reg || w_is_mvn) begin
          w_next = S_GET_B;
        end else if (w_is_add || w_is_cmp || w_is_and) begin
          w_next = S_GET_A;
        end else begin
          // Unrecognised encodings retire silently with no side effects.
          w_next = S_WAIT;
        end
      end
      S_WRITE_IMM: w_next = S_WAIT;
      S_GET_A:     w_next = S_GET_B;
      S_GET_B:     w_next = S_ALU;
      S_ALU:       w_next = w_is_cmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: w_next = S_WAIT;
      default:     w_next = S_WAIT;
    endcase
  end

  // Moore control strobes: everything idles at 0 unless the current state claims it.
  always_comb begin
    w        = 1'b0;
    writenum = 3'd0;
    readnum  = 3'd0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = 1'b0;
    ALUop    = 2'b00;
    case (r_state)
      S_WAIT: begin
        w = 1'b1;
      end
      S_WRITE_IMM: begin
        writenum = w_rn;
        vsel     = 1'b1;
        write    = 1'b1;
      end
      S_GET_A: begin
        readnum = w_rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = w_rm;
        loadb   = 1'b1;
      end
      S_ALU: begin
        // MOV reg passes B through the adder with A forced to zero.
        asel  = w_is_mov_reg;
        ALUop = w_is_mov_reg ? 2'b00 : w_op;
        if (w_is_cmp) begin
          loads = 1'b1;
        end else begin
          loadc = 1'b1;
        end
      end
      S_WRITE_REG: begin
        writenum = w_rd;
        write    = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_p3_controller.sv
// Bench for p3_controller: directed scenarios then randomized instructions.
// Per-cycle strobe sequences and latencies come from the instruction rules; a
// stand-in datapath driven by the strobes is compared with an architectural model.
module tb_p3_controller;

  logic        clk;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic        s;
  logic        w;
  logic [15:0] datapath_in;
  logic [2:0]  writenum;
  logic [2:0]  readnum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic        vsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;

  p3_controller dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .s(s), .w(w),
    .datapath_in(datapath_in), .writenum(writenum), .readnum(readnum),
    .write(write), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .ALUop(ALUop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int K_MOVI = 0, K_MOVR = 1, K_ADD = 2, K_CMP = 3, K_AND = 4, K_MVN = 5, K_BAD = 6;

  int n_checks = 0;
  int n_errors = 0;
  int write_cnt = 0;

  // Stand-in datapath driven by the controller strobes.
  logic [15:0] dp_r [8];
  logic [15:0] dp_a, dp_b, dp_c;
  logic        dp_z;

  // Architectural model.
  logic [15:0] m_r [8];
  logic        m_z;

  logic [31:0] seq [$];

  function automatic logic [15:0] shf(input logic [15:0] b, input logic [1:0] op);
    case (op)
      2'b00:   return b;
      2'b01:   return b << 1;
      2'b10:   return b >> 1;
      default: return 16'($signed(b) >>> 1);
    endcase
  endfunction

  function automatic logic [15:0] alu(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return ~b;
    endcase
  endfunction

  function automatic logic [15:0] sext8(input logic [15:0] i);
    return 16'($signed(i[7:0]));
  endfunction

  function automatic int klass(input logic [15:0] i);
    if (i[15:13] == 3'b110 && i[12:11] == 2'b10) return K_MOVI;
    if (i[15:13] == 3'b110 && i[12:11] == 2'b00) return K_MOVR;
    if (i[15:13] == 3'b101) return K_ADD + int'(i[12:11]);
    return K_BAD;
  endfunction

  function automatic int lat_of(input int k);
    case (k)
      K_MOVI:        return 3;
      K_MOVR, K_MVN: return 5;
      K_CMP:         return 5;
      K_ADD, K_AND:  return 6;
      default:       return 2;
    endcase
  endfunction

  // Control vector: {w, writenum, readnum, write, loada, loadb, loadc, loads, asel, bsel, vsel, ALUop}
  function automatic logic [31:0] mk(input logic w_, input logic [2:0] wn, input logic [2:0] rn,
                                     input logic wr, input logic la, input logic lb, input logic lc,
                                     input logic ls, input logic as_, input logic vs, input logic [1:0] aop);
    return {15'd0, w_, wn, rn, wr, la, lb, lc, ls, as_, 1'b0, vs, aop};
  endfunction

  function automatic logic [31:0] obs();
    return {15'd0, w, writenum, readnum, write, loada, loadb, loadc, loads, asel, bsel, vsel, ALUop};
  endfunction

  // Downstream datapath behaviour on each rising edge.
  always @(posedge clk) begin
    if (write) begin
      dp_r[writenum] <= vsel ? datapath_in : dp_c;
      write_cnt      <= write_cnt + 1;
    end
    if (loada) dp_a <= dp_r[readnum];
    if (loadb) dp_b <= dp_r[readnum];
    if (loadc) dp_c <= alu(asel ? 16'd0 : dp_a, bsel ? datapath_in : shf(dp_b, shift), ALUop);
    if (loads) dp_z <= (alu(asel ? 16'd0 : dp_a, bsel ? datapath_in : shf(dp_b, shift), ALUop) == 16'd0);
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_checks++;
    assert (o === e) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // Expected strobe sequence from the s edge until WAIT, one entry per busy cycle.
  task automatic build_seq(input logic [15:0] i);
    int k;
    logic [2:0] rn, rd, rm;
    logic [1:0] op;
    k  = klass(i);
    rn = i[10:8];
    rd = i[7:5];
    rm = i[2:0];
    op = i[12:11];
    seq.delete();
    seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    case (k)
      K_MOVI: seq.push_back(mk(0, rn, 0, 1, 0, 0, 0, 0, 0, 1, 2'b00));
      K_MOVR, K_MVN: begin
        seq.push_back(mk(0, 0, rm, 0, 0, 1, 0, 0, 0, 0, 2'b00));
        seq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, k == K_MOVR, 0, (k == K_MOVR) ? 2'b00 : op));
        seq.push_back(mk(0, rd, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00));
      end
      K_ADD, K_CMP, K_AND: begin
        seq.push_back(mk(0, 0, rn, 0, 1, 0, 0, 0, 0, 0, 2'b00));
        seq.push_back(mk(0, 0, rm, 0, 0, 1, 0, 0, 0, 0, 2'b00));
        seq.push_back(mk(0, 0, 0, 0, 0, 0, k != K_CMP, k == K_CMP, 0, 0, op));
        if (k != K_CMP) seq.push_back(mk(0, rd, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00));
      end
      default: begin
      end
    endcase
  endtask

  // Runs one instruction from WAIT (called at a falling edge).
  // mode 0: load+s together; 1: load then s next cycle; 2: s only (IR already holds i).
  task automatic exec(input logic [15:0] i, input int mode, input bit busy);
    int edges;
    int idx;
    build_seq(i);
    if (mode == 1) begin
      in = i; load = 1'b1; s = 1'b0;
      @(negedge clk);
      chk("wait_after_load", 32'(w), 32'd1);
      load = 1'b0;
    end
    in   = i;
    load = (mode == 0);
    s    = 1'b1;
    @(negedge clk);
    load = 1'b0; s = 1'b0;
    edges = 1;
    idx   = 0;
    while (w !== 1'b1 && edges < 12) begin
      load = 1'b0; s = 1'b0;
      if (idx < seq.size()) chk("strobes", obs(), seq[idx]);
      chk("datapath_in", 32'(datapath_in), 32'(sext8(i)));
      chk("shift", 32'(shift), 32'(i[4:3]));
      if (busy && idx == 1) begin
        in = 16'hD0FB; load = 1'b1; s = 1'b1;
      end
      idx++;
      @(negedge clk);
      edges++;
    end
    load = 1'b0; s = 1'b0;
    chk("latency", 32'(edges), 32'(lat_of(klass(i))));
    chk("idle_strobes", obs(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
  endtask

  task automatic arch(input logic [15:0] i);
    logic [15:0] a, b;
    a = m_r[i[10:8]];
    b = shf(m_r[i[2:0]], i[4:3]);
    case (klass(i))
      K_MOVI: m_r[i[10:8]] = sext8(i);
      K_MOVR: m_r[i[7:5]]  = b;
      K_ADD:  m_r[i[7:5]]  = a + b;
      K_CMP:  m_z          = ((a - b) == 16'd0);
      K_AND:  m_r[i[7:5]]  = a & b;
      K_MVN:  m_r[i[7:5]]  = ~b;
      default: begin
      end
    endcase
  endtask

  task automatic cmp_regs(input logic [15:0] i);
    for (int r = 0; r < 8; r++) chk($sformatf("R%0d", r), 32'(dp_r[r]), 32'(m_r[r]));
    if (klass(i) == K_CMP) chk("Z", 32'(dp_z), 32'(m_z));
  endtask

  task automatic run(input logic [15:0] i, input int mode, input bit busy);
    exec(i, mode, busy);
    arch(i);
    cmp_regs(i);
  endtask

  initial begin
    logic [15:0] ri;
    int          wc;
    int          k;

    in = 16'h0000; load = 1'b0; s = 1'b0; reset = 1'b0;
    #2 reset = 1'b1;
    #5;
    chk("reset_strobes", obs(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    chk("reset_dp_in", 32'(datapath_in), 32'd0);
    chk("reset_shift", 32'(shift), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Give every register a known value.
    for (int r = 0; r < 8; r++) begin
      ri = {3'b110, 2'b10, 3'(r), 8'($urandom)};
      run(ri, 1, 1'b0);
    end

    // MOV R0,#-5 with load and s together
    run(16'hD0FB, 0, 1'b0);
    chk("movi_r0", 32'(m_r[0]), 32'h0000FFFB);
    // ADD R2,R0,R1,LSL#1
    run(16'hA049, 0, 1'b0);
    // CMP R3,R4: no write expected
    wc = write_cnt;
    run(16'hAB04, 1, 1'b0);
    chk("cmp_no_write", 32'(write_cnt), 32'(wc));
    // MOV R7,R6 and MVN R1,R2
    run(16'hC0E6, 0, 1'b0);
    run(16'hB822, 0, 1'b0);
    // ADD with load/s pulsed mid-flight: must be ignored
    run(16'hA049, 0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      chk("busy_no_restart", 32'(w), 32'd1);
      chk("busy_ir_kept", 32'(datapath_in), 32'h00000049);
      @(negedge clk);
    end

    // Reset during GET_B of an ADD
    in = 16'hA049; load = 1'b1; s = 1'b1;
    @(negedge clk);
    load = 1'b0; s = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_getb", obs(), mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b00));
    wc = write_cnt;
    #2 reset = 1'b1;
    #1;
    chk("abort_strobes", obs(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    chk("abort_ir_zero", 32'(datapath_in), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exec(16'h0000, 2, 1'b0);
    chk("abort_no_write", 32'(write_cnt), 32'(wc));
    cmp_regs(16'h0000);

    // Randomized instructions
    for (int n = 0; n < 150; n++) begin
      k = int'($urandom_range(0, 6));
      case (k)
        K_MOVI: ri = {3'b110, 2'b10, 3'($urandom), 8'($urandom)};
        K_MOVR: ri = {3'b110, 2'b00, 11'($urandom)};
        K_BAD: begin
          ri = 16'($urandom);
          while (klass(ri) != K_BAD) ri = 16'($urandom);
        end
        default: ri = {3'b101, 2'(k - K_ADD), 11'($urandom)};
      endcase
      wc = write_cnt;
      run(ri, int'($urandom_range(0, 1)), 1'b0);
      if (klass(ri) == K_BAD || klass(ri) == K_CMP) chk("no_write_rand", 32'(write_cnt), 32'(wc));
      else chk("one_write_rand", 32'(write_cnt), 32'(wc + 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
